// File: rtl/wieg_regelaar_if.sv
// Purpose : bundles the controller's tick/verdict inputs and motor outputs into one port.
// Latency : none; this is wiring only.
// Backpressure: none; all signals are level or single-cycle strobes with no handshake.
//
// Signals
//   slow      : one-cycle tick strobe shared with the stress evaluation path
//   enable    : level-sensitive session request
//   gedaald   : stress decreased verdict (stable between slow ticks)
//   gelijk    : stress unchanged verdict
//   motor_aan : motor enable
//   niveau    : motor intensity level
//   kalm      : calm phase active
//   klaar     : session finished, motor stopped
//
// Modports
//   master : the environment side (stress block / session logic / motor driver)
//   slave  : the controller itself
interface wieg_regelaar_if #(
    parameter int LVL_W = 3
);
    logic             slow;
    logic             enable;
    logic             gedaald;
    logic             gelijk;
    logic             motor_aan;
    logic [LVL_W-1:0] niveau;
    logic             kalm;
    logic             klaar;

    modport master (
        output slow,
        output enable,
        output gedaald,
        output gelijk,
        input  motor_aan,
        input  niveau,
        input  kalm,
        input  klaar
    );

    modport slave (
        input  slow,
        input  enable,
        input  gedaald,
        input  gelijk,
        output motor_aan,
        output niveau,
        output kalm,
        output klaar
    );
endinterface

// File: rtl/wieg_regelaar.sv
// Purpose : closed-loop rocking-intensity controller; searches for a level that lowers stress, then ramps down.
// Latency : outputs registered; start visible 1 clock after enable, a new level 2 clocks after the last settle tick.
// Backpressure: none; slow ticks arriving during an evaluation cycle are dropped, verdicts are only sampled there.
//
// Ports
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   bus    : wieg_regelaar_if.slave (slow, enable, gedaald, gelijk in; motor_aan, niveau, kalm, klaar out)
//
// Operation in brief
//   IDLE      -> SETTLE on enable, applying START_LEVEL with the motor on and searching downwards.
//   SETTLE    -> EVAL after SETTLE_TICKS slow ticks.
//   EVAL      : one cycle; decides the next level from the stress verdict, or enters the calm phase
//               after CALM_ROUNDS decreases in a row (a "rose" verdict resets that count).
//   CALM_WAIT -> CALM_EVAL after SETTLE_TICKS slow ticks.
//   CALM_EVAL : one cycle; lowers the level while stress does not rise, stops the motor at level 0,
//               or falls back to an upward search if stress rose.
//   KLAAR     : outputs hold until enable drops.
//   Dropping enable in any non-IDLE state returns everything to reset values at the next edge.
module wieg_regelaar #(
    parameter int LVL_W        = 3,
    parameter int START_LEVEL  = 4,
    parameter int SETTLE_TICKS = 16,
    parameter int CALM_ROUNDS  = 3
) (
    input  logic             clk,
    input  logic             reset,
    wieg_regelaar_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_EVAL      = 3'd2,
        ST_CALM_WAIT = 3'd3,
        ST_CALM_EVAL = 3'd4,
        ST_KLAAR     = 3'd5
    } state_t;

    localparam logic [LVL_W-1:0] LVL_MAX   = '1;
    localparam logic [LVL_W-1:0] START_LVL = LVL_W'(START_LEVEL);
    localparam logic [7:0]       TCNT_LAST = 8'(SETTLE_TICKS - 1);
    localparam logic [3:0]       GCNT_CALM = 4'(CALM_ROUNDS);

    // Registered state and outputs
    state_t           r_state;
    logic [LVL_W-1:0] r_niveau;
    logic             r_motor_aan;
    logic             r_kalm;
    logic             r_klaar;
    logic             r_dir;      // 0: searching down, 1: searching up
    logic [7:0]       r_tcnt;     // slow ticks seen in the current window
    logic [3:0]       r_gcnt;     // consecutive "decreased" verdicts

    // Pre-computed step results, each packed as {new_dir, new_level}
    logic [LVL_W:0]   w_step_cur; // step in the current direction
    logic [LVL_W:0]   w_step_inv; // step after inverting the direction
    logic [LVL_W:0]   w_step_up;  // step with the direction forced upward
    logic [3:0]       w_gcnt_inc;
    logic             w_tick_last;
    logic             w_not_rose;

    // A step always moves exactly one level. At either end of the range the
    // direction flips and the move goes the other way, so the level never
    // holds and never wraps.
    function automatic logic [LVL_W:0] f_step(
        input logic [LVL_W-1:0] lvl,
        input logic             dir
    );
        logic [LVL_W:0] res;
        if (dir) begin
            if (lvl == LVL_MAX) begin
                res = {1'b0, lvl - 1'b1};
            end else begin
                res = {1'b1, lvl + 1'b1};
            end
        end else begin
            if (lvl == '0) begin
                res = {1'b1, lvl + 1'b1};
            end else begin
                res = {1'b0, lvl - 1'b1};
            end
        end
        return res;
    endfunction

    always_comb begin
        w_step_cur  = f_step(r_niveau, r_dir);
        w_step_inv  = f_step(r_niveau, ~r_dir);
        w_step_up   = f_step(r_niveau, 1'b1);
        w_gcnt_inc  = r_gcnt + 4'd1;
        w_tick_last = bus.slow && (r_tcnt == TCNT_LAST);
        w_not_rose  = bus.gedaald || bus.gelijk;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_niveau    <= '0;
            r_motor_aan <= 1'b0;
            r_kalm      <= 1'b0;
            r_klaar     <= 1'b0;
            r_dir       <= 1'b0;
            r_tcnt      <= '0;
            r_gcnt      <= '0;
        end else if ((r_state != ST_IDLE) && !bus.enable) begin
            // Session withdrawn: this wins over any decision in the same cycle,
            // including the normal KLAAR -> IDLE exit.
            r_state     <= ST_IDLE;
            r_niveau    <= '0;
            r_motor_aan <= 1'b0;
            r_kalm      <= 1'b0;
            r_klaar     <= 1'b0;
            r_dir       <= 1'b0;
            r_tcnt      <= '0;
            r_gcnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.enable) begin
                        r_state     <= ST_SETTLE;
                        r_niveau    <= START_LVL;
                        r_motor_aan <= 1'b1;
                        r_dir       <= 1'b0;
                        r_tcnt      <= '0;
                        r_gcnt      <= '0;
                    end
                end

                ST_SETTLE,
                ST_CALM_WAIT: begin
                    if (w_tick_last) begin
                        r_tcnt  <= '0;
                        r_state <= (r_state == ST_SETTLE) ? ST_EVAL : ST_CALM_EVAL;
                    end else if (bus.slow) begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end

                ST_EVAL: begin
                    if (bus.gedaald) begin
                        r_gcnt <= w_gcnt_inc;
                        if (w_gcnt_inc == GCNT_CALM) begin
                            // Enough improvement in a row: keep this level and start ramping down.
                            r_kalm  <= 1'b1;
                            r_state <= ST_CALM_WAIT;
                        end else begin
                            r_dir    <= w_step_cur[LVL_W];
                            r_niveau <= w_step_cur[LVL_W-1:0];
                            r_state  <= ST_SETTLE;
                        end
                    end else if (bus.gelijk) begin
                        r_dir    <= w_step_cur[LVL_W];
                        r_niveau <= w_step_cur[LVL_W-1:0];
                        r_state  <= ST_SETTLE;
                    end else begin
                        // Stress rose: the last move was wrong, so reverse the search.
                        r_gcnt   <= '0;
                        r_dir    <= w_step_inv[LVL_W];
                        r_niveau <= w_step_inv[LVL_W-1:0];
                        r_state  <= ST_SETTLE;
                    end
                end

                ST_CALM_EVAL: begin
                    if (w_not_rose) begin
                        if (r_niveau != '0) begin
                            r_niveau <= r_niveau - 1'b1;
                            r_state  <= ST_CALM_WAIT;
                        end else begin
                            r_motor_aan <= 1'b0;
                            r_kalm      <= 1'b0;
                            r_klaar     <= 1'b1;
                            r_state     <= ST_KLAAR;
                        end
                    end else begin
                        // Relapse while ramping down: resume the search from one level higher.
                        r_kalm   <= 1'b0;
                        r_gcnt   <= '0;
                        r_dir    <= w_step_up[LVL_W];
                        r_niveau <= w_step_up[LVL_W-1:0];
                        r_state  <= ST_SETTLE;
                    end
                end

                ST_KLAAR: begin
                    // Outputs hold; leaving happens through the enable-drop path above.
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.motor_aan = r_motor_aan;
    assign bus.niveau    = r_niveau;
    assign bus.kalm      = r_kalm;
    assign bus.klaar     = r_klaar;

endmodule
